// File: rtl/elastic_tracker_pkg.sv
// Shared types, reset values and width helpers for the elastic slot tracker.
package elastic_tracker_pkg;

    localparam int DEF_TAG_W = 4;

    typedef logic [DEF_TAG_W-1:0] tag_t;

    localparam logic VALID_RST       = 1'b0;
    localparam logic ALMOST_FULL_RST = 1'b0;

    // Occupancy must be able to represent 0..STAGE inclusive.
    function automatic int count_w(input int stage);
        return $clog2(stage + 1);
    endfunction

endpackage

// File: rtl/elastic_tracker_slot.sv
// One pipeline slot: valid bit plus side-band tag, loaded only when enabled.
module elastic_tracker_slot
    import elastic_tracker_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             d_valid,
    input  logic [TAG_W-1:0] d_tag,
    output logic             q_valid,
    output logic [TAG_W-1:0] q_tag
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= VALID_RST;
        end else if (clr) begin
            q_valid <= VALID_RST;
        end else if (en) begin
            q_valid <= d_valid;
        end
    end

    // Tag is meaningless without its valid bit, so flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_tag <= '0;
        end else if (en && !clr) begin
            q_tag <= d_tag;
        end
    end

endmodule

// File: rtl/elastic_slot_tracker.sv
// Bubble-collapsing valid/tag tracker for a fixed-depth pipeline: items enter at
// slot STAGE-1, compress toward slot 0 and leave from slot 0.
module elastic_slot_tracker
    import elastic_tracker_pkg::*;
#(
    parameter int STAGE    = 8,
    parameter int TAG_W    = 4,
    parameter int AF_LEVEL = STAGE - 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [TAG_W-1:0]            out_tag,
    input  logic                        out_ready,
    output logic [STAGE-1:0]            valid_vec,
    output logic [STAGE-1:0]            enable_vec,
    output logic [STAGE*TAG_W-1:0]      tag_vec,
    output logic [count_w(STAGE)-1:0]   occupancy,
    output logic                        full,
    output logic                        almost_full,
    output logic                        empty
);

    localparam int CW = count_w(STAGE);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);

    logic [STAGE-1:0]       d_valid;
    logic [STAGE*TAG_W-1:0] d_tag;
    logic                   accept;
    logic                   rel;
    logic [CW-1:0]          occ_next;

    // A slot may advance when it or anything below it has a bubble,
    // or when the consumer is draining slot 0.
    genvar i;
    generate
        for (i = 0; i < STAGE; i++) begin : g_slot
            assign enable_vec[i] = ~(&valid_vec[i:0]) | out_ready;

            if (i == STAGE - 1) begin : g_top
                assign d_valid[i]               = in_valid;
                assign d_tag[i*TAG_W +: TAG_W]  = in_tag;
            end else begin : g_mid
                assign d_valid[i]               = valid_vec[i+1];
                assign d_tag[i*TAG_W +: TAG_W]  = tag_vec[(i+1)*TAG_W +: TAG_W];
            end

            elastic_tracker_slot #(
                .TAG_W (TAG_W)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .clr     (flush),
                .en      (enable_vec[i]),
                .d_valid (d_valid[i]),
                .d_tag   (d_tag[i*TAG_W +: TAG_W]),
                .q_valid (valid_vec[i]),
                .q_tag   (tag_vec[i*TAG_W +: TAG_W])
            );
        end
    endgenerate

    assign full      = &valid_vec;
    assign empty     = (occupancy == '0);
    assign out_valid = valid_vec[0];
    assign out_tag   = tag_vec[TAG_W-1:0];

    // Ready is withheld during flush so no offered item is silently dropped.
    assign in_ready  = ~flush & (~full | out_ready);
    assign accept    = in_valid & in_ready;
    assign rel       = out_valid & out_ready;

    always_comb begin
        occ_next = occupancy;
        if (flush) begin
            occ_next = '0;
        end else if (accept && !rel) begin
            occ_next = occupancy + ONE;
        end else if (rel && !accept) begin
            occ_next = occupancy - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy   <= '0;
            almost_full <= ALMOST_FULL_RST;
        end else begin
            occupancy   <= occ_next;
            almost_full <= (occ_next >= AF_L);
        end
    end

endmodule

// File: tb/tb_elastic_slot_tracker.sv
// Directed and random checks of elastic_slot_tracker with STAGE=4, TAG_W=4, AF_LEVEL=3.
module tb_elastic_slot_tracker;
    import elastic_tracker_pkg::*;

    localparam int STAGE = 4;
    localparam int TAG_W = 4;
    localparam int AF    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    tag_t        in_tag = '0;
    logic        in_ready;
    logic        out_valid;
    tag_t        out_tag;
    logic        out_ready = 1'b0;
    logic [3:0]  valid_vec;
    logic [3:0]  enable_vec;
    logic [15:0] tag_vec;
    logic [2:0]  occupancy;
    logic        full;
    logic        almost_full;
    logic        empty;

    int total = 0;
    int bad   = 0;
    tag_t exp_q[$];

    elastic_slot_tracker #(
        .STAGE    (STAGE),
        .TAG_W    (TAG_W),
        .AF_LEVEL (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_tag      (in_tag),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_tag     (out_tag),
        .out_ready   (out_ready),
        .valid_vec   (valid_vec),
        .enable_vec  (enable_vec),
        .tag_vec     (tag_vec),
        .occupancy   (occupancy),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Reference FIFO of accepted tags; every release must match its head.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("fifo_underrun", 32'(out_tag), 32'hdead);
                else check("fifo_tag", 32'(out_tag), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back(in_tag);
        end
    end

    always @(negedge clk) begin
        check("occ_popcount", 32'(occupancy), 32'($countones(valid_vec)));
        check("flags", {29'd0, full, almost_full, empty},
              {29'd0, valid_vec == 4'hF, occupancy >= 3'(AF), occupancy == 3'd0});
    end

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        #1;
        check("rst_vv", 32'(valid_vec), 32'h0);
        check("rst_occ", 32'(occupancy), 32'h0);
        check("rst_flags", {29'd0, empty, full, almost_full}, 32'b100);
        check("rst_rdy", {30'd0, in_ready, out_valid}, 32'b10);

        // single item latency
        in_valid = 1'b1; in_tag = 4'hA;
        cyc(); in_valid = 1'b0; #1;
        check("lat_t1", 32'(valid_vec), 32'b1000);
        cyc(); #1 check("lat_t2", 32'(valid_vec), 32'b0100);
        cyc(); #1 check("lat_t3", 32'(valid_vec), 32'b0010);
        cyc(); #1 check("lat_t4", 32'(valid_vec), 32'b0001);
        check("lat_out", {27'd0, out_valid, out_tag}, {27'd0, 1'b1, 4'hA});
        cyc(); cyc(); #1;
        check("lat_hold", {27'd0, out_valid, out_tag}, {27'd0, 1'b1, 4'hA});
        out_ready = 1'b1;
        cyc(); out_ready = 1'b0; #1;
        check("lat_drain", {28'd0, occupancy, empty}, {28'd0, 3'd0, 1'b1});

        // fill to full with 1..4, then 5 is refused
        in_valid = 1'b1; in_tag = 4'h1;
        cyc(); in_tag = 4'h2; #1;
        check("fill1", {25'd0, valid_vec, occupancy}, {25'd0, 4'b1000, 3'd1});
        cyc(); in_tag = 4'h3; #1;
        check("fill2", {25'd0, valid_vec, occupancy}, {25'd0, 4'b1100, 3'd2});
        check("fill2_af", 32'(almost_full), 32'd0);
        cyc(); in_tag = 4'h4; #1;
        check("fill3", {25'd0, valid_vec, occupancy}, {25'd0, 4'b1110, 3'd3});
        check("fill3_af", {30'd0, almost_full, full}, 32'b10);
        cyc(); in_tag = 4'h5; #1;
        check("fill4", {25'd0, valid_vec, occupancy}, {25'd0, 4'b1111, 3'd4});
        check("fill4_full", 32'(full), 32'd1);
        check("full_rdy", 32'(in_ready), 32'd0);
        cyc(); #1;
        check("full_hold", {21'd0, valid_vec, occupancy, out_tag}, {21'd0, 4'b1111, 3'd4, 4'h1});

        // shift-through: release 1 while accepting 5
        out_ready = 1'b1; #1;
        check("st_rdy", 32'(in_ready), 32'd1);
        cyc(); in_valid = 1'b0; #1;
        check("st_occ", {28'd0, occupancy, full}, {28'd0, 3'd4, 1'b1});
        check("st_tag", 32'(out_tag), 32'h2);
        cyc(); #1;
        check("rel1_vv", {25'd0, valid_vec, occupancy}, {25'd0, 4'b0111, 3'd3});
        check("rel1_full", 32'(full), 32'd0);
        check("rel1_tag", 32'(out_tag), 32'h3);
        cyc(); #1 check("rel2_tag", 32'(out_tag), 32'h4);
        cyc(); #1 check("rel3_tag", 32'(out_tag), 32'h5);
        cyc(); out_ready = 1'b0; #1;
        check("rel_empty", {28'd0, valid_vec}, 32'h0);

        // flush with two items held and an offer pending
        in_valid = 1'b1; in_tag = 4'hB;
        cyc(); in_tag = 4'hC;
        cyc(); in_valid = 1'b0;
        cyc(); cyc(); #1;
        check("pre_flush", {25'd0, valid_vec, occupancy}, {25'd0, 4'b0011, 3'd2});
        flush = 1'b1; in_valid = 1'b1; in_tag = 4'hD; #1;
        check("flush_rdy", 32'(in_ready), 32'd0);
        check("flush_outv", 32'(out_valid), 32'd1);
        cyc(); flush = 1'b0; in_valid = 1'b0; #1;
        check("post_flush", {25'd0, valid_vec, occupancy}, {25'd0, 4'b0000, 3'd0});
        cyc(); #1;
        check("post_flush2", {28'd0, valid_vec}, 32'h0);

        // async reset with three items in flight
        in_valid = 1'b1; in_tag = 4'h7;
        cyc(); cyc(); cyc(); in_valid = 1'b0; #1;
        check("pre_rst", 32'(occupancy), 32'd3);
        #2 rst = 1'b1; #1;
        check("mid_rst", {27'd0, valid_vec, empty}, {27'd0, 4'b0000, 1'b1});
        check("mid_rst_occ", {28'd0, occupancy, in_ready}, {28'd0, 3'd0, 1'b1});
        cyc(); rst = 1'b0;

        // random traffic
        for (int n = 0; n < 10000; n++) begin
            cyc();
            in_valid  = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
        end
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        cyc(); #1;
        check("rand_qsize", 32'(occupancy), 32'(exp_q.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
